// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
//  Module   : freq_meter
//  Purpose  : Measures a slow asynchronous square wave against the system
//             clock. Once per gate window it reports how many rising edges
//             sig_in had. It also reports, continuously, how many clock
//             cycles separated the two most recent rising edges.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_100mhz     in   1      system clock; every flop uses its rising edge
//    rst            in   1      asynchronous, active-low reset
//    enable         in   1      1 = measure, 0 = abort the window and idle
//    sig_in         in   1      asynchronous signal under test
//    freq_count     out  CNT_W  rising edges in the last completed window
//    period_cycles  out  CNT_W  clk cycles between the last two rising edges
//    meas_valid     out  1      one-cycle pulse when freq_count updates
//    overflow       out  1      last window's edge count saturated
//    no_signal      out  1      no rising edge for >= GATE_CYCLES cycles
// ============================================================================
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 100_000_000,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_100mhz,
    input  logic             rst,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_count,
    output logic [CNT_W-1:0] period_cycles,
    output logic             meas_valid,
    output logic             overflow,
    output logic             no_signal
);

    // The gate counter is sized from GATE_CYCLES instead of CNT_W. This lets a
    // narrow result width still time a long window.
    localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    // Comparisons between the period counter and GATE_CYCLES use a width
    // that holds both numbers.
    localparam int unsigned CMP_W  = (CNT_W > 32) ? CNT_W : 32;

    localparam logic [GATE_W-1:0] C_GATE_LAST   = GATE_W'(GATE_CYCLES - 1);
    localparam logic [GATE_W-1:0] C_GATE_ONE    = GATE_W'(1);
    localparam logic [CNT_W-1:0]  C_CNT_MAX     = '1;
    localparam logic [CNT_W-1:0]  C_CNT_ONE     = CNT_W'(1);
    localparam logic [CMP_W-1:0]  C_NOSIG_LIMIT = CMP_W'(GATE_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_GATE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser and rising-edge detector
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_rise;

    always_ff @(posedge clk_100mhz or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

    // ------------------------------------------------------------------
    // Measurement state
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [GATE_W-1:0]   r_gate_cnt;
    logic [CNT_W-1:0]    r_edge_cnt;
    logic [CNT_W-1:0]    r_per_cnt;
    logic                r_have_edge;
    logic                r_ovf_flag;

    logic                w_gate_last;
    logic                w_edge_at_max;
    logic                w_sat_hit;
    logic [CNT_W-1:0]    w_edge_next;
    logic [CNT_W-1:0]    w_per_next;
    logic                w_per_at_limit;

    assign w_gate_last    = (r_gate_cnt == C_GATE_LAST);
    assign w_edge_at_max  = (r_edge_cnt == C_CNT_MAX);
    // A rise that arrives while the edge counter is full is lost. The
    // overflow flag records that the count has saturated.
    assign w_sat_hit      = w_rise & w_edge_at_max;
    assign w_edge_next    = (w_rise && !w_edge_at_max) ? (r_edge_cnt + C_CNT_ONE) : r_edge_cnt;
    // The saturated increment serves two purposes: advancing the period
    // counter, and giving the edge-to-edge distance (per_cnt + 1).
    assign w_per_next     = (r_per_cnt == C_CNT_MAX) ? r_per_cnt : (r_per_cnt + C_CNT_ONE);
    assign w_per_at_limit = (CMP_W'(r_per_cnt) >= C_NOSIG_LIMIT);

    always_ff @(posedge clk_100mhz or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_gate_cnt    <= '0;
            r_edge_cnt    <= '0;
            r_per_cnt     <= '0;
            r_have_edge   <= 1'b0;
            r_ovf_flag    <= 1'b0;
            freq_count    <= '0;
            period_cycles <= '0;
            meas_valid    <= 1'b0;
            overflow      <= 1'b0;
            no_signal     <= 1'b0;
        end else begin
            meas_valid <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // Results hold while idle. Working counters restart from
                    // zero so that the next window begins clean.
                    r_gate_cnt  <= '0;
                    r_edge_cnt  <= '0;
                    r_per_cnt   <= '0;
                    r_have_edge <= 1'b0;
                    r_ovf_flag  <= 1'b0;
                    if (enable) begin
                        r_state <= ST_GATE;
                    end
                end

                ST_GATE: begin
                    if (!enable) begin
                        // Abort: the partial window is discarded and no
                        // result is published.
                        r_state     <= ST_IDLE;
                        r_gate_cnt  <= '0;
                        r_edge_cnt  <= '0;
                        r_per_cnt   <= '0;
                        r_have_edge <= 1'b0;
                        r_ovf_flag  <= 1'b0;
                    end else begin
                        // Gate window: a rise on the terminal cycle belongs
                        // to the window that is closing.
                        if (w_gate_last) begin
                            freq_count <= w_edge_next;
                            overflow   <= r_ovf_flag | w_sat_hit;
                            meas_valid <= 1'b1;
                            r_gate_cnt <= '0;
                            r_edge_cnt <= '0;
                            r_ovf_flag <= 1'b0;
                        end else begin
                            r_gate_cnt <= r_gate_cnt + C_GATE_ONE;
                            r_edge_cnt <= w_edge_next;
                            if (w_sat_hit) begin
                                r_ovf_flag <= 1'b1;
                            end
                        end

                        // Period path: the first rise after entering the gate
                        // only arms the measurement.
                        if (w_rise) begin
                            if (r_have_edge) begin
                                period_cycles <= w_per_next;
                            end
                            r_have_edge <= 1'b1;
                            r_per_cnt   <= '0;
                            no_signal   <= 1'b0;
                        end else begin
                            r_per_cnt <= w_per_next;
                            if (w_per_at_limit) begin
                                no_signal <= 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
//  Module   : tb_freq_meter
//  Purpose  : Directed-sequence bench for freq_meter. It runs a 32-bit
//             instance and a 6-bit instance, with GATE_CYCLES=1000. Expected
//             results are computed from a recorded history of the input
//             waveform.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_freq_meter;

    localparam int GATE = 1000;
    localparam int S    = 2;
    localparam int HMAX = 131072;

    logic        clk = 1'b0;
    logic        rst, enable, sig_in, enable6, sig6;
    logic [31:0] freq_count, period_cycles;
    logic        meas_valid, overflow, no_signal;
    logic [5:0]  freq6, period6;
    logic        mv6, ovf6, ns6;

    always #1 clk = ~clk;

    freq_meter #(.GATE_CYCLES(GATE), .CNT_W(32), .SYNC_STAGES(S)) dut (
        .clk_100mhz(clk), .rst(rst), .enable(enable), .sig_in(sig_in),
        .freq_count(freq_count), .period_cycles(period_cycles),
        .meas_valid(meas_valid), .overflow(overflow), .no_signal(no_signal)
    );

    freq_meter #(.GATE_CYCLES(GATE), .CNT_W(6), .SYNC_STAGES(S)) dut6 (
        .clk_100mhz(clk), .rst(rst), .enable(enable6), .sig_in(sig6),
        .freq_count(freq6), .period_cycles(period6),
        .meas_valid(mv6), .overflow(ovf6), .no_signal(ns6)
    );

    // Waveform history: hist[n] holds what the first synchroniser flop
    // captured at rising edge n. It is forced to 0 while reset holds the
    // flops clear.
    int cyc = 0;
    bit hist  [HMAX];
    bit hist6 [HMAX];

    always @(posedge clk) begin
        if (cyc < HMAX - 1) cyc = cyc + 1;
        hist[cyc]  = rst ? sig_in : 1'b0;
        hist6[cyc] = rst ? sig6   : 1'b0;
    end

    // A rising edge that was first captured at clock edge n is acted on at
    // clock edge n+S, once it has passed through the chain and the previous-
    // value flop.
    function automatic bit rise_at(input int m, input bit which);
        if (m - S - 1 < 0) return 1'b0;
        if (which) return hist6[m-S] & ~hist6[m-S-1];
        return hist[m-S] & ~hist[m-S-1];
    endfunction

    function automatic int count_rises(input int a, input int b, input bit which);
        int n = 0;
        for (int m = a; m <= b; m++) n += int'(rise_at(m, which));
        return n;
    endfunction

    // Distance between the last two rises in (e, t]; -1 if fewer than two.
    function automatic int period_model(input int e, input int t, input bit which);
        int last = -1;
        int prev = -1;
        for (int m = t; m > e; m--) begin
            if (rise_at(m, which)) begin
                if (last < 0) last = m;
                else begin
                    prev = m;
                    break;
                end
            end
        end
        return (prev < 0) ? -1 : (last - prev);
    endfunction

    // ------------------------------------------------------------------
    // Stimulus generators
    // ------------------------------------------------------------------
    int gen_mode = 1;   // 0 hold, 1 fixed half period, 2 random half period
    int half     = 5;
    bit hold_val = 1'b0;
    bit run6     = 1'b0;

    initial begin : g_sig_gen
        int cnt = 0;
        sig_in = 1'b0;
        forever begin
            @(negedge clk);
            if (gen_mode == 0) begin
                sig_in = hold_val;
            end else if (cnt <= 1) begin
                sig_in = ~sig_in;
                cnt = (gen_mode == 1) ? half : int'($urandom_range(2, 9));
            end else begin
                cnt--;
            end
        end
    end

    initial begin : g_sig6_gen
        int c6 = 0;
        sig6 = 1'b0;
        forever begin
            @(negedge clk);
            if (run6) begin
                c6++;
                if (c6 >= 2) begin
                    sig6 = ~sig6;
                    c6 = 0;
                end
            end else begin
                sig6 = 1'b0;
                c6 = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int n_vec = 0;
    int n_err = 0;
    int last_freq = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_meas(input int budget, input bit which, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((which ? mv6 : meas_valid) === 1'b1) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            n_vec++;
            n_err++;
            $error("FAIL meas_timeout: observed no pulse expected pulse within %0d cycles", budget);
        end
    endtask

    task automatic wait_until(input int target);
        for (int i = 0; i < 4 * GATE && cyc < target; i++) @(negedge clk);
    endtask

    task automatic check_window(input string tag, input int e, input int k);
        int t, exp_f, p;
        wait_meas(GATE + 20, 1'b0, t);
        if (t >= 0) begin
            check({tag, "_time"}, t, e + k * GATE);
            exp_f = count_rises(e + (k - 1) * GATE + 1, e + k * GATE, 1'b0);
            check({tag, "_freq"}, freq_count, exp_f);
            check({tag, "_ovf"}, overflow, 1'b0);
            check({tag, "_nosig"}, no_signal, 1'b0);
            p = period_model(e, t, 1'b0);
            if (p > 0) check({tag, "_period"}, period_cycles, p);
            last_freq = exp_f;
        end
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin : g_main
        int e, e6, t, cnt, p, pulses, c0;
        bit seen;

        rst = 1'b0; enable = 1'b0; enable6 = 1'b0;

        // Reset held with the input toggling
        repeat (20) @(negedge clk);
        check("reset_main", {freq_count, period_cycles, meas_valid, overflow, no_signal}, 0);
        check("reset_w6", {freq6, period6, mv6, ovf6, ns6}, 0);
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("idle_main", {freq_count, period_cycles, meas_valid, overflow, no_signal}, 0);
        end

        // Narrow counter saturates
        run6 = 1'b1;
        repeat (10) @(negedge clk);
        enable6 = 1'b1;
        e6 = cyc + 1;
        for (int k = 1; k <= 2; k++) begin
            wait_meas(GATE + 20, 1'b1, t);
            if (t >= 0) begin
                check("sat_time", t, e6 + k * GATE);
                cnt = count_rises(e6 + (k - 1) * GATE + 1, e6 + k * GATE, 1'b1);
                check("sat_freq", freq6, (cnt > 63) ? 63 : cnt);
                check("sat_ovf", ovf6, (cnt > 63) ? 1 : 0);
                p = period_model(e6, t, 1'b1);
                if (p > 0) check("sat_period", period6, p);
            end
        end
        enable6 = 1'b0;
        run6 = 1'b0;
        check("idle_main_after_sat", {freq_count, meas_valid}, 0);

        // Steady 10-cycle period, then random half periods
        enable = 1'b1;
        e = cyc + 1;
        check_window("fix_w1", e, 1);
        check_window("fix_w2", e, 2);
        gen_mode = 2;
        check_window("rnd_w3", e, 3);
        check_window("rnd_w4", e, 4);
        gen_mode = 1;
        check_window("fix_w5", e, 5);

        // Abort mid-window, results hold, re-enable restarts the window
        repeat (500) @(negedge clk);
        c0 = cyc;
        enable = 1'b0;
        pulses = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (meas_valid === 1'b1) pulses++;
        end
        check("abort_no_valid", pulses, 0);
        check("abort_freq_hold", freq_count, last_freq);
        p = period_model(e, c0, 1'b0);
        if (p > 0) check("abort_period_hold", period_cycles, p);
        enable = 1'b1;
        e = cyc + 1;
        check_window("reen_w1", e, 1);

        // Reset pulse mid-window
        repeat (300) @(negedge clk);
        rst = 1'b0;
        #0.5;
        check("rst_mid_zero", {freq_count, period_cycles, meas_valid, overflow, no_signal}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        e = cyc + 1;
        check_window("postrst_w1", e, 1);
        check_window("postrst_w2", e, 2);

        // No signal, then a single edge
        enable = 1'b0;
        gen_mode = 0;
        hold_val = 1'b0;
        repeat (30) @(negedge clk);
        enable = 1'b1;
        e = cyc + 1;
        wait_until(e + GATE - 1);
        check("nosig_before", no_signal, 1'b0);
        @(negedge clk);
        check("nosig_set", no_signal, 1'b1);
        check("nosig_valid1", meas_valid, 1'b1);
        check("nosig_freq1", freq_count, count_rises(e + 1, e + GATE, 1'b0));
        wait_until(e + 2 * GATE);
        check("nosig_valid2", meas_valid, 1'b1);
        check("nosig_freq2", freq_count, count_rises(e + GATE + 1, e + 2 * GATE, 1'b0));
        check("nosig_held", no_signal, 1'b1);
        hold_val = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rise_at(cyc, 1'b0)) seen = 1'b1;
            check("nosig_clear", no_signal, seen ? 1'b0 : 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
